// File: rtl/sr_pkg.sv
// Shared types and constants for the SR latch sequencer: FSM states,
// operation encodings, default pulse/gap widths and a counter sizing helper.
package sr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic OP_SET = 1'b1;
  localparam logic OP_CLR = 1'b0;

  localparam int DEF_PULSE_W = 4;
  localparam int DEF_GAP_W   = 4;

  // One down-counter serves both PULSE and GAP, so it must hold the larger width.
  function automatic int cnt_width(input int pw, input int gw);
    return $clog2(((pw > gw) ? pw : gw) + 1);
  endfunction

endpackage

// File: rtl/sr_latch_seq_if.sv
// Requester-side handshake bundle for sr_latch_seq: two req/op/ack channels.
// Handshake: req is raised with a stable op and held until ack; ack is a
// one-cycle pulse, and the requester drops req in the cycle after ack.
interface sr_latch_seq_if;
  logic a_req;
  logic a_op;
  logic a_ack;
  logic b_req;
  logic b_op;
  logic b_ack;

  modport master (
    output a_req, a_op, b_req, b_op,
    input  a_ack, b_ack
  );

  modport slave (
    input  a_req, a_op, b_req, b_op,
    output a_ack, b_ack
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. The pointer remembers the last grantee,
// so on a tie the other requester wins; reset leaves B as last, so A wins first.
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic elig_a,
  input  logic elig_b,
  input  logic ptr_en,
  output logic gnt_a,
  output logic gnt_b
);

  logic last_b_q;

  assign gnt_a = elig_a & (~elig_b | last_b_q);
  assign gnt_b = elig_b & (~elig_a | ~last_b_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b_q <= 1'b1;
    end else if (ptr_en && (gnt_a || gnt_b)) begin
      last_b_q <= gnt_b;
    end
  end

endmodule

// File: rtl/sr_latch_seq.sv
// Sequencer driving the active-low S/R inputs of a cross-coupled latch on behalf
// of two requesters. Optional readback check is enabled by defining SR_CHECK_EN.
module sr_latch_seq
  import sr_pkg::*;
#(
  parameter int PULSE_W = DEF_PULSE_W,
  parameter int GAP_W   = DEF_GAP_W
) (
  input  logic            clk,
  input  logic            rst_n,
  sr_latch_seq_if.slave   req_if,
  output logic            s_n,
  output logic            r_n,
  output logic            busy,
  output logic            q_exp,
  output logic            q_valid,
  input  logic            q_fb,
  output logic            err,
  output state_t          state_dbg
);

  localparam int CW = cnt_width(PULSE_W, GAP_W);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            op_q, op_d;
  logic            sel_q, sel_d;     // 1 = B holds the current grant
  logic            skip_q, skip_d;
  logic            q_exp_q, q_exp_d;
  logic            q_valid_q, q_valid_d;
  logic            s_n_q, s_n_d;
  logic            r_n_q, r_n_d;

  logic            last_gap;
  logic            ack_pend;
  logic            idle_ok;
  logic            elig_a, elig_b;
  logic            gnt_a, gnt_b;
  logic            ptr_en;
  logic            gnt_op;

  assign last_gap = (state_q == GAP) && (cnt_q == CW'(1));
  assign ack_pend = skip_q | last_gap;

  assign req_if.a_ack = ack_pend & ~sel_q;
  assign req_if.b_ack = ack_pend &  sel_q;

  // A skip ack occupies the cycle after the grant, so no new grant until it retires.
  assign idle_ok = (state_q == IDLE) && !skip_q;
  assign elig_a  = idle_ok & req_if.a_req & ~req_if.a_ack;
  assign elig_b  = idle_ok & req_if.b_req & ~req_if.b_ack;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .elig_a (elig_a),
    .elig_b (elig_b),
    .ptr_en (ptr_en),
    .gnt_a  (gnt_a),
    .gnt_b  (gnt_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= OP_CLR;
      sel_q     <= 1'b0;
      skip_q    <= 1'b0;
      q_exp_q   <= 1'b0;
      q_valid_q <= 1'b0;
      s_n_q     <= 1'b1;
      r_n_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      sel_q     <= sel_d;
      skip_q    <= skip_d;
      q_exp_q   <= q_exp_d;
      q_valid_q <= q_valid_d;
      s_n_q     <= s_n_d;
      r_n_q     <= r_n_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    sel_d     = sel_q;
    skip_d    = 1'b0;
    q_exp_d   = q_exp_q;
    q_valid_d = q_valid_q;
    ptr_en    = 1'b0;
    gnt_op    = gnt_b ? req_if.b_op : req_if.a_op;

    unique case (state_q)
      IDLE: begin
        if (gnt_a || gnt_b) begin
          ptr_en = 1'b1;
          sel_d  = gnt_b;
          if (q_valid_q && (gnt_op == q_exp_q)) begin
            skip_d = 1'b1;
          end else begin
            state_d = PULSE;
            cnt_d   = CW'(PULSE_W);
            op_d    = gnt_op;
          end
        end
      end
      PULSE: begin
        if (cnt_q == CW'(1)) begin
          state_d = GAP;
          cnt_d   = CW'(GAP_W);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      GAP: begin
        if (last_gap) begin
          state_d   = IDLE;
          cnt_d     = '0;
          q_exp_d   = op_q;
          q_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Pulse levels come straight from flops; op is one bit, so both low is impossible.
    s_n_d = !((state_d == PULSE) && (op_d == OP_SET));
    r_n_d = !((state_d == PULSE) && (op_d == OP_CLR));
  end

  assign s_n       = s_n_q;
  assign r_n       = r_n_q;
  assign busy      = (state_q != IDLE);
  assign q_exp     = q_exp_q;
  assign q_valid   = q_valid_q;
  assign state_dbg = state_q;

`ifdef SR_CHECK_EN
  // Two-flop synchronizer latency is why GAP_W must cover at least three cycles.
  logic [1:0] fb_sync_q;
  logic       err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_sync_q <= 2'b00;
      err_q     <= 1'b0;
    end else begin
      fb_sync_q <= {fb_sync_q[0], q_fb};
      if (last_gap && (fb_sync_q[1] != op_q)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  logic unused_q_fb;
  assign unused_q_fb = q_fb;
  assign err         = 1'b0;
`endif

endmodule

// File: doc/sr_latch_seq.md
# sr_latch_seq

Clocked sequencer that owns the active-low set/reset inputs of a cross-coupled SR latch and shares them between two requesters. It arbitrates set/clear requests round-robin, generates glitch-free registered pulses of fixed width, and guarantees that S and R are never low together. A recovery gap follows every pulse. The block tracks the latch's expected state, so redundant requests complete without pulsing. It sits between the control logic and the SR latch in the lab datapath.

## Interface
- PULSE_W, 4, cycles s_n/r_n held low per operation (≥1)
- GAP_W, 4, idle cycles after each pulse before the next grant (≥1; ≥3 when SR_CHECK_EN defined)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- a_req  in  1  requester A request, held until a_ack
- a_op  in  1  requester A operation: 1 = set, 0 = clear; stable while a_req high
- a_ack  out  1  one-cycle completion pulse to A
- b_req, b_op, b_ack  same as A, for requester B
- s_n  out  1  latch set input, active-low, registered
- r_n  out  1  latch reset input, active-low, registered
- busy  out  1  FSM not in IDLE
- q_exp  out  1  expected latch Q
- q_valid  out  1  q_exp is meaningful (at least one pulse completed since reset)
- q_fb  in  1  latch Q readback, asynchronous to clk; used only with SR_CHECK_EN
- err  out  1  sticky readback-mismatch flag; constant 0 without SR_CHECK_EN

## Operation
- Reset values: s_n=1, r_n=1, a_ack=0, b_ack=0, busy=0, q_exp=0, q_valid=0, err=0. The round-robin pointer resets to "B last", so A wins the first tie.
- The FSM has three states: IDLE, PULSE, GAP. A single down-counter of width $clog2(max(PULSE_W,GAP_W)+1) serves both PULSE and GAP.
- In IDLE, a requester is eligible if its req=1 and its ack is not high in the same cycle.
  - One eligible requester: grant it.
  - Both eligible: grant the one not granted last, then update the pointer.
- Skip rule: if q_valid=1 and the granted op equals q_exp, the FSM stays in IDLE. The granted requester's ack pulses next cycle and no s_n/r_n activity occurs.
- Otherwise the FSM enters PULSE and latches op.
  - op=1 drives s_n=0 and r_n=1.
  - op=0 drives r_n=0 and s_n=1.
  - The pulse lasts exactly PULSE_W cycles.
- PULSE→GAP: s_n=r_n=1, counter loads GAP_W.
- GAP→IDLE after GAP_W cycles. On the last GAP cycle:
  - the granted ack pulses;
  - q_exp is set to op;
  - q_valid is set to 1.
- s_n=0 and r_n=0 together is illegal in every state. Both are decoded from registered state only.
- Requests that arrive during PULSE or GAP wait; they are never dropped.
- Requesters must drop req in the cycle after ack. A req still high in the ack cycle is ignored for that cycle.

## Timing
- Request seen in IDLE at cycle 0:
  - the selected pulse input is low for cycles 1..PULSE_W;
  - GAP covers cycles PULSE_W+1..PULSE_W+GAP_W;
  - ack is high in cycle PULSE_W+GAP_W;
  - the next grant can occur in cycle PULSE_W+GAP_W+1.
- Skip path: ack in cycle 1; the next grant can occur in cycle 2.
- Back-to-back throughput is one operation per PULSE_W+GAP_W+1 cycles.
- Reset asserted mid-PULSE: s_n/r_n return to 1 asynchronously, q_valid clears, and the pending ack is never issued.

## Configuration
- SR_CHECK_EN defined:
  - q_fb passes through a two-flop synchronizer.
  - On the last GAP cycle, the synchronized value is compared with op.
  - A mismatch sets err, which stays set until reset. The ack is still issued.
- SR_CHECK_EN undefined: no synchronizer or compare logic; q_fb is unused and err is tied 0.

## Structure
- Shared package sr_pkg holds:
  - the state enum (IDLE, PULSE, GAP);
  - OP_SET=1 and OP_CLR=0;
  - the default PULSE_W and GAP_W.
- One sub-module, rr_arb2: a two-requester round-robin arbiter with eligibility inputs, grant outputs, and a pointer update enable.

## Test plan
- Reset, then A requests set (a_op=1) with defaults → s_n low in cycles 1–4, r_n never low, a_ack in cycle 8, q_exp=1, q_valid=1.
- A and B request in the same cycle (A set, B clear) → A pulses first, then B. r_n low in cycles 10–13, b_ack in cycle 17, q_exp=0.
- After a completed set, B requests set → no pulse, b_ack in the next cycle, q_exp unchanged.
- rst_n dropped in cycle 2 of a pulse → s_n=1 immediately, no ack, q_valid=0. The next request always pulses.
- SR_CHECK_EN defined, q_fb tied 0, set request → err=1 after the ack cycle and stays 1. A later clear does not clear err.
- Throughout all runs, assert that s_n and r_n are never both 0 and that each ack is exactly one cycle wide.
